// File: rtl/glitch_wishbone.sv
// Wishbone-programmed clock glitch generator: delay/width engine gating clk_in onto clk_out.
// Optional feature: define GLITCH_DEBUG_MODE_EN to let MODE 0x05 drive the pulse straight onto clk_out.
module glitch_wishbone (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] dat_i,
  input  logic [5:2] adr_i,
  output logic [7:0] dat_o,
  input  logic       stb_i,
  input  logic       we_i,
  output logic       ack_o,
  input  logic       clk_in,
  output logic       clk_out
);
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_WIDTH} state_t;

  state_t      state, state_n;
  logic [15:0] delay_q, dcnt, dcnt_n;
  logic [7:0]  width_q, mode_q, wcnt, wcnt_n, wlat, wlat_n;
  logic [7:0]  rd_data;
  logic        g, wr, trig;

  assign wr   = stb_i & we_i;
  assign trig = wr && (adr_i == 4'h0) && dat_i[0] && (state == S_IDLE);

  // Width is latched at arming so config writes during DELAY cannot alter the pulse.
  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    wcnt_n  = wcnt;
    wlat_n  = wlat;
    case (state)
      S_IDLE: if (trig) begin
        wlat_n = width_q;
        if (delay_q != 16'd0) begin
          state_n = S_DELAY;
          dcnt_n  = delay_q - 16'd1;
        end else if (width_q != 8'd0) begin
          state_n = S_WIDTH;
          wcnt_n  = width_q - 8'd1;
        end
      end
      S_DELAY: begin
        if (dcnt == 16'd0) begin
          if (wlat != 8'd0) begin
            state_n = S_WIDTH;
            wcnt_n  = wlat - 8'd1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          dcnt_n = dcnt - 16'd1;
        end
      end
      S_WIDTH: begin
        if (wcnt == 8'd0) state_n = S_IDLE;
        else              wcnt_n  = wcnt - 8'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // g is its own flop so clk_out never sees state-decode hazards.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
      dcnt  <= 16'd0;
      wcnt  <= 8'd0;
      wlat  <= 8'd0;
      g     <= 1'b0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
      wcnt  <= wcnt_n;
      wlat  <= wlat_n;
      g     <= (state_n == S_WIDTH);
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (adr_i)
      4'h0: rd_data = {7'd0, state == S_IDLE};
      4'h1: rd_data = delay_q[7:0];
      4'h2: rd_data = delay_q[15:8];
      4'h3: rd_data = width_q;
      4'h4: rd_data = mode_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o   <= 1'b0;
      dat_o   <= 8'h00;
      delay_q <= 16'd0;
      width_q <= 8'd0;
      mode_q  <= 8'd0;
    end else begin
      ack_o <= stb_i;
      if (stb_i && !we_i) dat_o <= rd_data;
      if (wr) begin
        case (adr_i)
          4'h1: delay_q[7:0]  <= dat_i;
          4'h2: delay_q[15:8] <= dat_i;
          4'h3: width_q       <= dat_i;
          4'h4: mode_q        <= dat_i;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    clk_out = clk_in;
    case (mode_q)
      8'h01: clk_out = clk_in & ~g;
      8'h02: clk_out = clk_in | g;
      8'h03: clk_out = g ? ~(clk_in & clk_i) : clk_in;
      8'h04: clk_out = clk_in ^ g;
`ifdef GLITCH_DEBUG_MODE_EN
      8'h05: clk_out = g;
`else
      8'h05: clk_out = clk_in;
`endif
      default: clk_out = clk_in;
    endcase
  end
endmodule

// File: tb/tb_glitch_wishbone.sv
// Bench for glitch_wishbone: register vector table, bus scoreboard and per-cycle clk_out model.
module tb_glitch_wishbone;
  logic       clk_i = 1'b0, rst_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, clk_in = 1'b0;
  logic [7:0] dat_i = 8'h00, dat_o;
  logic [5:2] adr_i = 4'h0;
  logic       ack_o, clk_out;

  int n_cmp = 0, n_bad = 0;

  typedef struct {logic we; logic [3:0] adr; logic [7:0] dat;} vec_t;
  typedef struct {logic rd; logic [7:0] exp;} sb_t;
  vec_t vecs[17];
  sb_t  q[$];
  logic [7:0] last_rd = 8'h00;

  glitch_wishbone dut (
    .clk_i(clk_i), .rst_i(rst_i), .dat_i(dat_i), .adr_i(adr_i), .dat_o(dat_o),
    .stb_i(stb_i), .we_i(we_i), .ack_o(ack_o), .clk_in(clk_in), .clk_out(clk_out)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, got, want);
    end
  endtask

  // Bus monitor: ack must follow every sampled strobe; reads pop expected data.
  initial forever begin
    logic s;
    sb_t  r;
    @(posedge clk_i);
    s = stb_i && rst_i;
    #1;
    if (!rst_i) last_rd = 8'h00;
    else begin
      chk("ack", {7'd0, ack_o}, {7'd0, s});
      if (ack_o) begin
        if (q.size() == 0) chk("sb_underflow", 8'h01, 8'h00);
        else begin
          r = q.pop_front();
          if (r.rd) begin
            chk("rd_data", dat_o, r.exp);
            last_rd = r.exp;
          end else chk("dat_hold", dat_o, last_rd);
        end
      end
    end
  end

  // Drive one access at the current negedge; returns one cycle later with stb still high.
  task automatic wb(input logic we, input logic [3:0] adr, input logic [7:0] dat);
    stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
    q.push_back('{rd: !we, exp: dat});
    @(negedge clk_i);
  endtask

  function automatic logic model(input logic [7:0] m, input logic ci, input logic g, input logic ck);
    case (m)
      8'h01: return ci & ~g;
      8'h02: return ci | g;
      8'h03: return g ? ~(ci & ck) : ci;
      8'h04: return ci ^ g;
`ifdef GLITCH_DEBUG_MODE_EN
      8'h05: return g;
`endif
      default: return ci;
    endcase
  endfunction

  // Sample clk_out for both clk_in levels in cycle k after the trigger edge.
  task automatic chk_out(input int k, input int d, input int w, input logic [7:0] m);
    logic ge;
    ge = (k >= d + 1) && (k <= d + w);
    for (int ci = 0; ci < 2; ci++) begin
      clk_in = ci[0];
      #1;
      chk($sformatf("clk_out m=%0h k=%0d ci=%0d", m, k, ci), {7'd0, clk_out},
          {7'd0, model(m, ci[0], ge, clk_i)});
    end
    clk_in = 1'b0;
  endtask

  task automatic cfg(input int d, input int w, input logic [7:0] m);
    wb(1'b1, 4'h1, d[7:0]);
    wb(1'b1, 4'h2, d[15:8]);
    wb(1'b1, 4'h3, w[7:0]);
    wb(1'b1, 4'h4, m);
  endtask

  // Arm, then check clk_out every cycle; one extra bus access may be issued at cycle acc_k.
  task automatic glitch_run(input int d, input int w, input logic [7:0] m, input int acc_k,
                            input logic acc_we, input logic [3:0] acc_adr,
                            input logic [7:0] acc_dat, input int ncyc);
    cfg(d, w, m);
    wb(1'b1, 4'h0, 8'h01);
    for (int k = 1; k <= ncyc; k++) begin
      if (k == acc_k) begin
        stb_i = 1'b1; we_i = acc_we; adr_i = acc_adr; dat_i = acc_dat;
        q.push_back('{rd: !acc_we, exp: acc_dat});
      end else stb_i = 1'b0;
      chk_out(k, d, w, m);
      @(negedge clk_i);
    end
    stb_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 8'h01};
    vecs[1]  = '{1'b0, 4'h1, 8'h00};
    vecs[2]  = '{1'b0, 4'h2, 8'h00};
    vecs[3]  = '{1'b0, 4'h3, 8'h00};
    vecs[4]  = '{1'b0, 4'h4, 8'h00};
    vecs[5]  = '{1'b1, 4'h1, 8'hAB};
    vecs[6]  = '{1'b1, 4'h2, 8'hCD};
    vecs[7]  = '{1'b1, 4'h3, 8'hAF};
    vecs[8]  = '{1'b1, 4'h4, 8'hDC};
    vecs[9]  = '{1'b0, 4'h1, 8'hAB};
    vecs[10] = '{1'b0, 4'h2, 8'hCD};
    vecs[11] = '{1'b0, 4'h3, 8'hAF};
    vecs[12] = '{1'b0, 4'h4, 8'hDC};
    vecs[13] = '{1'b1, 4'h7, 8'h55};
    vecs[14] = '{1'b0, 4'h7, 8'h00};
    vecs[15] = '{1'b0, 4'hF, 8'h00};
    vecs[16] = '{1'b0, 4'h0, 8'h01};

    repeat (3) @(negedge clk_i);
    chk("rst_ack", {7'd0, ack_o}, 8'h00);
    chk("rst_dat", dat_o, 8'h00);
    chk("rst_clk_out", {7'd0, clk_out}, {7'd0, clk_in});
    rst_i = 1'b1;
    @(negedge clk_i);

    foreach (vecs[i]) wb(vecs[i].we, vecs[i].adr, vecs[i].dat);
    stb_i = 1'b0;
    @(negedge clk_i);

    // Full cycle in NOTHING mode: busy right after arming, ready again later.
    glitch_run(8, 4, 8'h00, 1, 1'b0, 4'h0, 8'h00, 24);
    wb(1'b0, 4'h0, 8'h01);
    stb_i = 1'b0;
    // Pulse placement and ready boundary
    glitch_run(8, 4, 8'h02, 0, 1'b0, 4'h0, 8'h00, 16);
    glitch_run(3, 2, 8'h02, 5, 1'b0, 4'h0, 8'h00, 8);
    glitch_run(3, 2, 8'h02, 6, 1'b0, 4'h0, 8'h01, 8);
    glitch_run(0, 8, 8'h02, 0, 1'b0, 4'h0, 8'h00, 12);
    glitch_run(8, 0, 8'h02, 4, 1'b0, 4'h0, 8'h00, 12);
    glitch_run(0, 0, 8'h02, 1, 1'b0, 4'h0, 8'h01, 4);
    // Gate modes
    glitch_run(4, 4, 8'h01, 0, 1'b0, 4'h0, 8'h00, 10);
    glitch_run(4, 4, 8'h03, 0, 1'b0, 4'h0, 8'h00, 10);
    glitch_run(4, 4, 8'h04, 0, 1'b0, 4'h0, 8'h00, 10);
    glitch_run(4, 4, 8'h05, 0, 1'b0, 4'h0, 8'h00, 10);
    glitch_run(4, 4, 8'h07, 0, 1'b0, 4'h0, 8'h00, 10);
    // Busy: re-trigger ignored, width write does not touch the running pulse
    glitch_run(6, 3, 8'h02, 3, 1'b1, 4'h0, 8'h01, 14);
    glitch_run(6, 3, 8'h02, 2, 1'b1, 4'h3, 8'h20, 14);
    wb(1'b0, 4'h3, 8'h20);
    stb_i = 1'b0;
    // Max width
    glitch_run(2, 255, 8'h02, 0, 1'b0, 4'h0, 8'h00, 260);

    // Reset during WIDTH releases the gate at once
    cfg(2, 6, 8'h01);
    wb(1'b1, 4'h0, 8'h01);
    stb_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk_out(k, 2, 6, 8'h01);
      if (k < 4) @(negedge clk_i);
    end
    rst_i = 1'b0;
    #1;
    for (int ci = 0; ci < 2; ci++) begin
      clk_in = ci[0];
      #1;
      chk("rst_gate", {7'd0, clk_out}, {7'd0, ci[0]});
    end
    clk_in = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    wb(1'b0, 4'h0, 8'h01);
    wb(1'b0, 4'h3, 8'h00);
    stb_i = 1'b0;

    repeat (3) @(negedge clk_i);
    chk("sb_empty", 8'(q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/glitch_wishbone.md
# glitch_wishbone

Wishbone-slave clock glitch generator. A host programs a 16-bit delay, an 8-bit pulse width and a gate mode over an 8-bit register bus, then arms it. The block counts the delay, asserts a glitch pulse for the programmed width, and modifies the passed-through target clock (`clk_in` → `clk_out`) according to the mode. It sits between the system Wishbone bus and the target clock pin.

## Interface
Parameters: none.
- `clk_i`  in  1  system/bus clock; all registers and counters run on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `dat_i`  in  8  write data.
- `adr_i`  in  [5:2] (4)  register word address.
- `dat_o`  out  8  read data, registered.
- `stb_i`  in  1  access strobe.
- `we_i`  in  1  1 = write, 0 = read.
- `ack_o`  out  1  access acknowledge, registered.
- `clk_in`  in  1  target clock to be glitched (asynchronous to `clk_i`).
- `clk_out`  out  1  glitched target clock.

## Operation
Register map (`adr_i`):
- 0x0 STATUS
  - Read: bit0 = ready (1 when idle); bits 7:1 = 0.
  - Write: bit0 = 1 while idle triggers.
- 0x1 DELAY_0: delay[7:0], R/W.
- 0x2 DELAY_1: delay[15:8], R/W.
- 0x3 WIDTH: width[7:0], R/W.
- 0x4 MODE: 8-bit R/W; all bits stored and read back.
- 0x5–0xF: read 0, writes ignored, still acknowledged.

Reset values: DELAY_0, DELAY_1, WIDTH and MODE are 0x00. STATUS reads 0x01. State is IDLE, `ack_o`=0, `dat_o`=0x00.

Engine FSM (IDLE, DELAY, WIDTH):
- **Arming:** a STATUS write with bit0=1 in IDLE latches delay D and width W into working counters.
- **From IDLE:** go to DELAY if D>0; else WIDTH if W>0; else stay IDLE.
- **DELAY:** lasts exactly D `clk_i` cycles, then goes to WIDTH (if W>0) or IDLE.
- **WIDTH:** lasts exactly W cycles with internal pulse `g`=1, then goes to IDLE.
- **Trigger while busy:** a STATUS write in DELAY or WIDTH is ignored.
- **Config writes while busy:** they update the registers but not the running counters.
- **Ready:** ready = (state == IDLE).

Output gating:
- Outside the pulse, `clk_out` = `clk_in` in every mode except ENABLE.
- During the pulse (g=1), by MODE value:
  - 0x00 NOTHING: `clk_in`.
  - 0x01 AND: `clk_in & ~g`, i.e. forced 0.
  - 0x02 OR: `clk_in | g`, i.e. forced 1.
  - 0x03 NAND: `~(clk_in & clk_i)`, a high-rate disturbance.
  - 0x04 XOR: `clk_in ^ g`, i.e. inverted.
  - 0x05 ENABLE: `clk_out` = g at all times (debug).
  - Any other value: same as NOTHING.
- `clk_out` is combinational from `clk_in`, g and MODE; g is a registered `clk_i`-domain signal.

Reset mid-operation: the FSM returns to IDLE immediately, g=0 and `clk_out`=`clk_in`.

## Timing
Bus access:
- `stb_i` is sampled at a rising edge of `clk_i`.
- At that same edge: a write is committed; `ack_o` is set to 1 for exactly one cycle; on a read, `dat_o` is loaded.
- `dat_o` holds its value until the next read.
- One access per strobe. A strobe held for N cycles produces N accesses and N acks.

Trigger timing:
- The trigger write edge is the edge of the STATUS write.
- A STATUS read issued on the next cycle returns 0x00, provided D+W>0.
- g is high for cycles D+1 through D+W after the trigger edge.
- Ready returns at cycle D+W+1.
- D=0, W=0: ready never drops.
- Delay arithmetic is 16-bit unsigned: D=0xFFFF gives 65535 cycles. W=0xFF gives 255 cycles.

## Configuration
- `GLITCH_DEBUG_MODE_EN`
  - Defined: MODE 0x05 (ENABLE) drives g directly onto `clk_out`.
  - Undefined: 0x05 is treated as NOTHING (`clk_out`=`clk_in`). The MODE register still stores and reads back all 8 bits.

## Test plan
- **Reset:** after reset, reads STATUS=0x01, DELAY_0=0x00, DELAY_1=0x00, WIDTH=0x00 → `ack_o` pulses one cycle after each strobe.
- **Register R/W:** write DELAY_0=0xAB, DELAY_1=0xCD, WIDTH=0xAF, MODE=0xDC → each reads back the same value.
- **Full cycle:** D=8, W=4, MODE=0. Write STATUS=0x01 → immediate STATUS read returns 0x00; after 25 `clk_i` cycles returns 0x01; g high for exactly 4 cycles.
- **Edge counts:**
  - D=0, W=8: g high 8 cycles starting one cycle after trigger.
  - D=8, W=0: STATUS reads 0x00 during delay, g never asserts.
- **Gate modes:** D=4, W=4.
  - AND → `clk_out` 0 during pulse.
  - OR → 1 during pulse.
  - XOR → `~clk_in` during pulse.
  - NOTHING → `clk_out` identical to `clk_in`.
  - ENABLE (macro defined) → `clk_out` equals g.
- **Busy and reset:** re-trigger write during DELAY is ignored (timing unchanged). Asserting `rst_i` low during WIDTH → `clk_out`=`clk_in` immediately and STATUS=0x01 after release.
